// File: rtl/btn_sample_ctrl.sv
// Button sampling controller: gates the 128 Hz divider, turns its output into a sample tick,
// debounces N buttons on that tick and produces press and auto-repeat pulses.
module btn_sample_ctrl #(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 3,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16,
    parameter int IDLE_TICKS   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             div_out,
    output logic             div_enable,
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] rpt,
    output logic             busy
);
    localparam logic [3:0] STABLE_C = 4'(STABLE_TICKS);
    localparam logic [7:0] DELAY_C  = 8'(REPEAT_DELAY);
    localparam logic [7:0] RELOAD_C = 8'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [7:0] IDLE_C   = 8'(IDLE_TICKS);

    typedef enum logic [1:0] {IDLE, WAKE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [N_BTN-1:0] btn_meta_reg, btn_s_reg;
    logic             div_meta_reg, div_s_reg, div_prev_reg;
    logic             div_enable_reg, busy_reg;
    logic [N_BTN-1:0] held_reg, held_next;
    logic [N_BTN-1:0] press_reg, press_next;
    logic [N_BTN-1:0] rpt_reg, rpt_next;
    logic [N_BTN-1:0] accept, cnt_nz;
    logic [3:0]       cnt_reg  [N_BTN];
    logic [3:0]       cnt_next [N_BTN];
    logic [7:0]       rep_cnt_reg, rep_cnt_next;
    logic [7:0]       idle_cnt_reg, idle_cnt_next;
    logic             tick, sample, quiet, held_changed, to_idle;

    // div_prev_reg is held low while parked, so only ticks of an enabled divider count.
    assign tick   = div_enable_reg & div_s_reg & ~div_prev_reg;
    assign sample = tick & ((state_reg == WAKE) | (state_reg == RUN));

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi = gi + 1) begin : g_btn
            logic differs;
            logic stable_hit;
            assign differs     = btn_s_reg[gi] ^ held_reg[gi];
            assign stable_hit  = (cnt_reg[gi] + 4'd1) == STABLE_C;
            assign accept[gi]  = sample & differs & stable_hit;
            assign cnt_next[gi] = !sample ? cnt_reg[gi] :
                                  (!differs || stable_hit) ? 4'd0 : cnt_reg[gi] + 4'd1;
            assign cnt_nz[gi]  = |cnt_next[gi];
        end
    endgenerate

    assign held_next    = held_reg ^ accept;
    assign press_next   = accept & btn_s_reg;
    assign held_changed = |accept;
    assign quiet        = (held_next == '0) && (btn_s_reg == '0) && (cnt_nz == '0);

    // A change of held restarts the repeat timer and suppresses rpt for that tick.
    always_comb begin
        rep_cnt_next = rep_cnt_reg;
        rpt_next     = '0;
        if (sample) begin
            if (held_changed || !$onehot(held_next)) begin
                rep_cnt_next = '0;
            end else if (rep_cnt_reg + 8'd1 == DELAY_C) begin
                rpt_next     = held_next;
                rep_cnt_next = RELOAD_C;
            end else begin
                rep_cnt_next = rep_cnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if (sample) begin
            if (!quiet) begin
                idle_cnt_next = '0;
            end else if (idle_cnt_reg != IDLE_C) begin
                idle_cnt_next = idle_cnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (btn_s_reg != held_reg) state_next = WAKE;
            WAKE:    if (tick) state_next = RUN;
            RUN:     if (idle_cnt_reg == IDLE_C) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign to_idle = (state_reg == RUN) && (state_next == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            btn_meta_reg   <= '0;
            btn_s_reg      <= '0;
            div_meta_reg   <= 1'b0;
            div_s_reg      <= 1'b0;
            div_prev_reg   <= 1'b0;
            div_enable_reg <= 1'b0;
            busy_reg       <= 1'b0;
            held_reg       <= '0;
            press_reg      <= '0;
            rpt_reg        <= '0;
            rep_cnt_reg    <= '0;
            idle_cnt_reg   <= '0;
            for (int i = 0; i < N_BTN; i++) cnt_reg[i] <= '0;
        end else begin
            btn_meta_reg   <= btn_raw;
            btn_s_reg      <= btn_meta_reg;
            div_meta_reg   <= div_out;
            div_s_reg      <= div_meta_reg;
            div_prev_reg   <= div_enable_reg ? div_s_reg : 1'b0;
            state_reg      <= state_next;
            div_enable_reg <= (state_next != IDLE);
            busy_reg       <= (state_next != IDLE);
            press_reg      <= press_next;
            rpt_reg        <= rpt_next;
            rep_cnt_reg    <= rep_cnt_next;
            idle_cnt_reg   <= to_idle ? 8'd0 : idle_cnt_next;
            held_reg       <= to_idle ? '0 : held_next;
            for (int i = 0; i < N_BTN; i++) cnt_reg[i] <= to_idle ? 4'd0 : cnt_next[i];
        end
    end

    assign div_enable = div_enable_reg;
    assign busy       = busy_reg;
    assign held       = held_reg;
    assign press      = press_reg;
    assign rpt        = rpt_reg;

endmodule
